// File: rtl/writeback_regfile.sv
// MIPS writeback stage and 32-entry architectural register file.
// Selects the writeback value, commits it, and serves two bypassed ID read ports.
module writeback_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WriteRegIn,
    input  logic                  MemToRegIn,
    input  logic [DATA_WIDTH-1:0] dataMemoryDataIn,
    input  logic [DATA_WIDTH-1:0] ALUResultIn,
    input  logic [ADDR_WIDTH-1:0] registerIn,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic [DATA_WIDTH-1:0] wbData,
    output logic [CNT_WIDTH-1:0]  wbCount
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  commit;
    logic                  bypass_on;

    assign wbData = MemToRegIn ? dataMemoryDataIn : ALUResultIn;
    assign commit = WriteRegIn && (registerIn != '0);

    // Bypass is suppressed while reset is held so reads are zero for any index.
    assign bypass_on = commit && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[registerIn] <= wbData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbCount <= '0;
        end else if (commit && (wbCount != {CNT_WIDTH{1'b1}})) begin
            wbCount <= wbCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        readData1 = regs[readReg1];
        if (readReg1 == '0) begin
            readData1 = '0;
        end else if (bypass_on && (readReg1 == registerIn)) begin
            readData1 = wbData;
        end
    end

    always_comb begin
        readData2 = regs[readReg2];
        if (readReg2 == '0) begin
            readData2 = '0;
        end else if (bypass_on && (readReg2 == registerIn)) begin
            readData2 = wbData;
        end
    end

endmodule
